cic_comb_decim: RTL and testbench
=================================

Name: cic_comb_decim

Overview:
- Comb and decimation back-end of the 3-stage CIC decimator. It completes the datapath whose front-end is the free-running 3-stage integrator section.
- Accepts the 37-bit integrator output at the input sample rate and keeps every R-th sample.
- Runs three first-difference comb stages (differential delay M=1) on the kept samples.
- Emits a scaled, truncated filtered sample with a one-cycle valid strobe at rate fs/R.

Parameters:
- IN_W, 37: width of the integrator data input and of all comb arithmetic.
- R, 5: decimation factor; legal range 1..64.
- SHIFT, 7: arithmetic right shift applied to the comb output. 7 = ceil(log2((R*M)^3)) for R=5, M=1.
- OUT_W, 10: output width, taken from bits [OUT_W-1:0] of the shifted value.

Ports:
- clk, input, 1: system clock, same clock as the integrator section.
- rst, input, 1: reset, asynchronous, active-high.
- din, input, IN_W: signed integrator output (two's complement, wraps mod 2^IN_W).
- din_vld, input, 1: din valid this cycle; the integrator section drives it 1 every cycle.
- dout, output, OUT_W: signed filtered, decimated sample.
- dout_vld, output, 1: one-cycle strobe, high when dout is updated.

Behaviour:
- Reset (async, rst=1): the following are all 0 immediately and stay 0 while rst=1.
  - Phase counter cnt, capture register s0.
  - Comb delay registers d1..d3, comb registers c1..c3.
  - Valid pipeline v0..v3, dout, dout_vld.
- Decimation counter:
  - cnt range 0..R-1, advances only on clock edges with din_vld=1.
  - At an edge with din_vld=1 and cnt==R-1: s0 <= din, v0 <= 1, cnt <= 0.
  - At any other din_vld=1 edge: cnt <= cnt+1, v0 <= 0. When din_vld=0: cnt holds, v0 <= 0.
  - The first kept sample after reset is the R-th valid input.
  - For R=1 every valid input is kept.
- Comb pipeline: one stage per clock, each stage updates only when its input valid is set. All arithmetic is IN_W-bit modulo 2^IN_W, with no saturation. Wrap in din is expected and cancels exactly.
  - v0=1: c1 <= s0 - d1; d1 <= s0; v1 <= 1, else v1 <= 0.
  - v1=1: c2 <= c1 - d2; d2 <= c1; v2 <= 1, else v2 <= 0.
  - v2=1: c3 <= c2 - d3; d3 <= c2; v3 <= 1, else v3 <= 0.
  - v3=1: dout <= (c3 >>> SHIFT)[OUT_W-1:0], dout_vld <= 1, else dout_vld <= 0.
- Output rounding and timing:
  - Truncation is toward minus infinity; there is no rounding.
  - dout holds its value between strobes.
- Latency: the capturing edge is E. dout_vld is high in the cycle following edge E+4, and dout shows the new value in that same cycle.
- Throughput: one output per R valid inputs. The pipeline never stalls, and back-to-back kept samples (R=1) produce back-to-back strobes.
- Reset mid-operation:
  - Every in-flight sample is discarded and comb history is cleared.
  - After release, the first output again appears after R valid inputs + 4 edges.
  - The first 3 outputs after reset are the comb start-up transient and are not suppressed.

Decomposition:
- Shared package cic_pkg holds:
  - CIC_N=3, CIC_M=1, CIC_R=5, CIC_IN_W=37, CIC_SHIFT=7, CIC_OUT_W=10.
  - A function computing the bit growth N*ceil(log2(R*M)), reused by the integrator section and by the top level.
- One natural sub-module: cic_comb_stage, parameter W, ports clk, rst, en, x, y, vld_o. It is instantiated 3 times in a chain.

Test Plan:
- Impulse response:
  - Setup: SHIFT=0, OUT_W=37, R=5, din_vld=1.
  - Stimulus: din=100 constant from reset release.
  - Required dout sequence: 100, -200, 100, 0, 0, ...
  - Required timing: strobes every 5 cycles; the first strobe 4 edges after the 5th valid input.
- Wrap-around:
  - Setup: SHIFT=0, OUT_W=37, R=1.
  - Stimulus: din = 2^36-10 + 5k (wraps past 2^36-1 to negative).
  - Required: dout = 0 from the 4th output onward, with no glitch at the wrap.
- Full chain with default parameters:
  - Setup: integrator section feeding this block, Xin=+3 constant.
  - Required: after the transient (4th output onward), dout = (3*125)>>>7 = 2 every 5 cycles.
  - Same setup with Xin=-3: dout = -3.
- Gapped valid:
  - Stimulus: din_vld toggling 1,0,1,0,...
  - Required: exactly one dout_vld per 5 valid inputs (i.e. per 10 clk). Values equal the gap-free run.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while v1/v2 are set.
  - Required: dout=0 and dout_vld=0 immediately. No strobe appears from the flushed sample.
  - Required: the next strobe comes at 5 valid inputs + 4 edges after release, with the start-up transient repeating (100, -200, 100 in the impulse setup).

Source files
------------

// File: rtl/cic_pkg.sv
// Shared constants and helpers for the 3-stage CIC decimator (integrator front-end
// and comb/decimation back-end).
package cic_pkg;

  localparam int CIC_N     = 3;
  localparam int CIC_M     = 1;
  localparam int CIC_R     = 5;
  localparam int CIC_IN_W  = 37;
  localparam int CIC_SHIFT = 7;
  localparam int CIC_OUT_W = 10;

  function automatic int cic_clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

  // Register growth of an N-stage CIC: N * ceil(log2(R*M)).
  function automatic int cic_bit_growth(input int n, input int r, input int m);
    return n * cic_clog2(r * m);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One first-difference comb stage (M=1): y <= x - x_prev on each enabled cycle,
// with a registered valid that follows the enable by one clock.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = CIC_IN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         vld_o
);

  logic [W-1:0] dly_q;
  logic [W-1:0] dly_d;
  logic [W-1:0] y_q;
  logic [W-1:0] y_d;
  logic         vld_q;
  logic         vld_d;

  // Difference is modulo 2^W so integrator wrap cancels exactly.
  always_comb begin
    dly_d = dly_q;
    y_d   = y_q;
    vld_d = 1'b0;
    if (en) begin
      y_d   = x - dly_q;
      dly_d = x;
      vld_d = 1'b1;
    end else begin
      y_d   = y_q;
      dly_d = dly_q;
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q <= '0;
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      dly_q <= dly_d;
      y_q   <= y_d;
      vld_q <= vld_d;
    end
  end

  assign y     = y_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/cic_comb_decim.sv
// Comb and decimation back-end of the 3-stage CIC decimator: keeps every R-th
// valid integrator sample, runs three comb stages and emits a scaled, truncated result.
module cic_comb_decim
  import cic_pkg::*;
#(
  parameter int IN_W  = CIC_IN_W,
  parameter int R     = CIC_R,
  parameter int SHIFT = CIC_SHIFT,
  parameter int OUT_W = CIC_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  din,
  input  logic             din_vld,
  output logic [OUT_W-1:0] dout,
  output logic             dout_vld
);

  // A single-stage growth of R is exactly the phase counter width.
  localparam int CNT_GROWTH = cic_bit_growth(1, R, 1);
  localparam int CNT_W      = (CNT_GROWTH < 1) ? 1 : CNT_GROWTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(R - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [IN_W-1:0]  s0_q;
  logic [IN_W-1:0]  s0_d;
  logic             v0_q;
  logic             v0_d;
  logic [OUT_W-1:0] dout_q;
  logic [OUT_W-1:0] dout_d;
  logic             dout_vld_q;
  logic             dout_vld_d;

  logic [IN_W-1:0]  c1_s;
  logic [IN_W-1:0]  c2_s;
  logic [IN_W-1:0]  c3_s;
  logic             v1_s;
  logic             v2_s;
  logic             v3_s;
  logic [IN_W-1:0]  c3_sh_s;

  always_comb begin
    cnt_d = cnt_q;
    s0_d  = s0_q;
    v0_d  = 1'b0;
    if (din_vld) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        s0_d  = din;
        v0_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        s0_d  = s0_q;
        v0_d  = 1'b0;
      end
    end else begin
      cnt_d = cnt_q;
      s0_d  = s0_q;
      v0_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      s0_q  <= '0;
      v0_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      s0_q  <= s0_d;
      v0_q  <= v0_d;
    end
  end

  cic_comb_stage #(.W(IN_W)) u_comb1 (
    .clk   (clk),
    .rst   (rst),
    .en    (v0_q),
    .x     (s0_q),
    .y     (c1_s),
    .vld_o (v1_s)
  );

  cic_comb_stage #(.W(IN_W)) u_comb2 (
    .clk   (clk),
    .rst   (rst),
    .en    (v1_s),
    .x     (c1_s),
    .y     (c2_s),
    .vld_o (v2_s)
  );

  cic_comb_stage #(.W(IN_W)) u_comb3 (
    .clk   (clk),
    .rst   (rst),
    .en    (v2_s),
    .x     (c2_s),
    .y     (c3_s),
    .vld_o (v3_s)
  );

  // Arithmetic shift truncates toward minus infinity; no rounding term.
  assign c3_sh_s = $signed(c3_s) >>> SHIFT;

  generate
    if (OUT_W < IN_W) begin : g_drop_msbs
      logic unused_sh_msbs_s;
      assign unused_sh_msbs_s = ^c3_sh_s[IN_W-1:OUT_W];
    end
  endgenerate

  always_comb begin
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    if (v3_s) begin
      dout_d     = c3_sh_s[OUT_W-1:0];
      dout_vld_d = 1'b1;
    end else begin
      dout_d     = dout_q;
      dout_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_cic_comb_decim.sv
// Directed bench for cic_comb_decim: impulse, reset mid-operation, gapped valid,
// wrap-around (R=1) and the full default chain with a bench-side integrator.
module tb_cic_comb_decim;

  localparam logic [36:0] WRAP_BASE = 37'h0F_FFFF_FFF6;  // 2^36 - 10

  logic        clk;
  logic        rst;

  logic [36:0] din_a;
  logic        din_vld_a;
  logic [36:0] dout_a;
  logic        dout_vld_a;

  logic [36:0] din_b;
  logic        din_vld_b;
  logic [36:0] dout_b;
  logic        dout_vld_b;

  logic [36:0] din_c;
  logic        din_vld_c;
  logic [9:0]  dout_c;
  logic        dout_vld_c;

  logic signed [36:0] i1;
  logic signed [36:0] i2;
  logic signed [36:0] i3;

  int n_checks;
  int n_pass;

  cic_comb_decim #(.IN_W(37), .R(5), .SHIFT(0), .OUT_W(37)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_vld(din_vld_a),
    .dout(dout_a), .dout_vld(dout_vld_a)
  );

  cic_comb_decim #(.IN_W(37), .R(1), .SHIFT(0), .OUT_W(37)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_vld(din_vld_b),
    .dout(dout_b), .dout_vld(dout_vld_b)
  );

  cic_comb_decim dut_c (
    .clk(clk), .rst(rst), .din(din_c), .din_vld(din_vld_c),
    .dout(dout_c), .dout_vld(dout_vld_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic longint imp_val(input int i);
    case (i)
      0:       return 100;
      1:       return -200;
      2:       return 100;
      default: return 0;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst dout_a", $signed(dout_a), 0);
    check("rst vld_a", longint'(dout_vld_a), 0);
    rst = 1'b0;
  endtask

  // din=100 constant into dut_a; strobes at edge 'first' then every 'period'.
  task automatic run_a(input int ncyc, input bit gapped, input string tg);
    int     first;
    int     period;
    int     idx;
    bit     strobe;
    longint held;
    first  = gapped ? 13 : 9;
    period = gapped ? 10 : 5;
    idx    = 0;
    held   = 0;
    din_a  = 37'd100;
    for (int n = 1; n <= ncyc; n++) begin
      din_vld_a = gapped ? n[0] : 1'b1;
      @(posedge clk);
      @(negedge clk);
      strobe = (n >= first) && (((n - first) % period) == 0);
      check($sformatf("%s vld n=%0d", tg, n), longint'(dout_vld_a), longint'(strobe));
      if (strobe) begin
        held = imp_val(idx);
        idx++;
      end
      check($sformatf("%s dout n=%0d", tg, n), $signed(dout_a), held);
    end
  endtask

  task automatic run_b();
    longint exp_v;
    din_vld_b = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      din_b = WRAP_BASE + 37'(5 * k);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("wrap vld k=%0d", k), longint'(dout_vld_b), (k >= 5) ? 1 : 0);
      case (k)
        1, 2, 3, 4: exp_v = 0;
        5:          exp_v = 64'h0000_000F_FFFF_FFFB;  // 2^36 - 5
        6:          exp_v = 15;
        7:          exp_v = 64'h0000_000F_FFFF_FFF6;  // 2^36 - 10
        default:    exp_v = 0;
      endcase
      check($sformatf("wrap dout k=%0d", k), $signed(dout_b), exp_v);
    end
    din_vld_b = 1'b0;
  endtask

  // Bench-side 3-stage integrator feeding dut_c with constant x.
  task automatic run_c(input longint x, input longint exp_ss, input string tg);
    int  idx;
    bit  strobe;
    i1 = '0;
    i2 = '0;
    i3 = '0;
    idx = 0;
    din_vld_c = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      i1 = i1 + 37'(x);
      i2 = i2 + i1;
      i3 = i3 + i2;
      din_c = i3;
      @(posedge clk);
      @(negedge clk);
      strobe = (n >= 9) && (((n - 9) % 5) == 0);
      check($sformatf("%s vld n=%0d", tg, n), longint'(dout_vld_c), longint'(strobe));
      if (strobe) begin
        idx++;
        if (idx >= 4) begin
          check($sformatf("%s dout out=%0d", tg, idx), $signed(dout_c), exp_ss);
        end
      end
    end
    din_vld_c = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    din_a     = 37'd100;
    din_vld_a = 1'b1;
    din_b     = '0;
    din_vld_b = 1'b0;
    din_c     = '0;
    din_vld_c = 1'b0;
    i1 = '0;
    i2 = '0;
    i3 = '0;

    repeat (3) @(negedge clk);
    check("init dout_a", $signed(dout_a), 0);
    check("init vld_a", longint'(dout_vld_a), 0);
    check("init dout_b", $signed(dout_b), 0);
    check("init vld_b", longint'(dout_vld_b), 0);
    check("init dout_c", $signed(dout_c), 0);
    check("init vld_c", longint'(dout_vld_c), 0);
    rst = 1'b0;

    // Impulse run, interrupted while kept sample 3 sits in v1.
    run_a(16, 1'b0, "imp1");
    rst = 1'b1;
    #1;
    check("midrst dout", $signed(dout_a), 0);
    check("midrst vld", longint'(dout_vld_a), 0);
    @(negedge clk);
    check("midrst hold dout", $signed(dout_a), 0);
    check("midrst hold vld", longint'(dout_vld_a), 0);
    rst = 1'b0;
    run_a(30, 1'b0, "imp2");

    do_reset();
    run_a(45, 1'b1, "gap");

    do_reset();
    run_b();

    do_reset();
    run_c(3, 2, "chain+3");

    do_reset();
    run_c(-3, -3, "chain-3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
